// File: rtl/io_pkg.sv
// Shared constants for input conditioning blocks.
// Default synchroniser depth and debounce length.
package io_pkg;

  localparam int IO_SYNC_STAGES     = 2;
  localparam int IO_DEBOUNCE_CYCLES = 16;

  // Debounce counter width, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-stage synchroniser for a bus of independent bits.
// Last stage is the only output safe for clk-domain logic.
module sync_chain #(
  parameter int   WIDTH       = 1,
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift raw inputs through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        stage[i] <= {WIDTH{RESET_LEVEL}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect raw input pins.
// One shared sync chain, one counter per channel.
module input_conditioner
  import io_pkg::*;
#(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = IO_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] synced;
  logic [CHANNELS-1:0] accept;

  sync_chain #(
    .WIDTH       (CHANNELS),
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (async_in),
    .q     (synced)
  );

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [CW-1:0] count;
    logic          lvl;
    logic          rs;
    logic          fl;

    assign accept[ch] = (synced[ch] != lvl) && (count == CNT_MAX);

    // Count consecutive differing samples; flip level on a full run.
    always_ff @(posedge clk) begin
      if (reset) begin
        count <= '0;
        lvl   <= RESET_LEVEL;
        rs    <= 1'b0;
        fl    <= 1'b0;
      end else begin
        rs <= accept[ch] & synced[ch];
        fl <= accept[ch] & ~synced[ch];
        if (synced[ch] == lvl) begin
          count <= '0;
        end else if (count == CNT_MAX) begin
          lvl   <= synced[ch];
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end

    assign level[ch] = lvl;
    assign rise[ch]  = rs;
    assign fall[ch]  = fl;
  end

  // Any channel accepting a change pulses in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else       changed <= |accept;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed cases plus random
// stimulus against a sample-history model, two configurations.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] async_in = 4'hF;

  logic [3:0] level_a, rise_a, fall_a;
  logic       changed_a;
  logic [3:0] level_b, rise_b, fall_b;
  logic       changed_b;

  always #5 clk = ~clk;

  input_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .async_in(async_in),
    .level(level_a), .rise(rise_a), .fall(fall_a),
    .changed(changed_a)
  );

  input_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(3),
    .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .async_in(async_in),
    .level(level_b), .rise(rise_b), .fall(fall_b),
    .changed(changed_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Model: level flips once the last D synced samples, all taken
  // after the previous flip or reset, differ from the held level.
  // The synced sample seen at edge k is the input driven before
  // edge k-S, or the reset level if that edge was not after reset.
  localparam int NE = 4096;
  int         sdep [2] = '{2, 3};
  int         dlen [2] = '{4, 1};
  logic [3:0] in_at [NE];
  int         e = 0;
  int         rst_edge = 0;
  bit         armed = 1'b0;
  int         last_ev [2][4];
  logic [3:0] m_level [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];

  function automatic logic synced_at(input int m, input int k,
                                     input int ch);
    int src;
    src = k - sdep[m];
    if (src <= rst_edge || src < 1) return 1'b0;
    return in_at[src][ch];
  endfunction

  always @(posedge clk) begin
    e++;
    if (e >= NE) begin
      $display("FAIL edge_budget: got %0d expected <%0d", e, NE);
      $fatal(1, "edge budget exceeded");
    end
    in_at[e] = async_in;
    if (reset) begin
      rst_edge = e;
      armed = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_level[m] = 4'h0;
        m_rise[m]  = 4'h0;
        m_fall[m]  = 4'h0;
        for (int ch = 0; ch < 4; ch++) last_ev[m][ch] = e;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_rise[m] = 4'h0;
        m_fall[m] = 4'h0;
        for (int ch = 0; ch < 4; ch++) begin
          bit ok;
          ok = 1'b1;
          for (int j = 0; j < dlen[m]; j++) begin
            int k;
            k = e - j;
            if (k <= last_ev[m][ch] ||
                synced_at(m, k, ch) == m_level[m][ch])
              ok = 1'b0;
          end
          if (ok) begin
            m_level[m][ch] = ~m_level[m][ch];
            if (m_level[m][ch]) m_rise[m][ch] = 1'b1;
            else                m_fall[m][ch] = 1'b1;
            last_ev[m][ch] = e;
          end
        end
      end
    end
  end

  // Every cycle after the first reset edge, compare both DUTs.
  always @(negedge clk) begin
    if (armed) begin
      check("cycle_a",
            {16'h0, level_a, rise_a, fall_a, 3'b0, changed_a},
            {16'h0, m_level[0], m_rise[0], m_fall[0], 3'b0,
             |(m_rise[0] | m_fall[0])});
      check("cycle_b",
            {16'h0, level_b, rise_b, fall_b, 3'b0, changed_b},
            {16'h0, m_level[1], m_rise[1], m_fall[1], 3'b0,
             |(m_rise[1] | m_fall[1])});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 3 edges with all inputs high.
    repeat (3) begin
      tick();
      check("rst_hold", {level_a, rise_a, fall_a, 3'b0, changed_a}, 0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) begin
        check("rel_level", level_a, 4'h0);
        check("rel_changed", changed_a, 1'b0);
      end else begin
        check("rel_level6", level_a, 4'hF);
        check("rel_rise6", rise_a, 4'hF);
      end
      if (i == 3) check("b_rel_level3", level_b, 4'h0);
      if (i == 4) check("b_rel_level4", level_b, 4'hF);
    end

    // Single rising step on channel 0.
    async_in = 4'h0;
    repeat (12) tick();
    async_in = 4'h1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i < 6) check("step_level", level_a[0], 1'b0);
      if (i == 6) begin
        check("step_level6", level_a[0], 1'b1);
        check("step_rise6", rise_a, 4'h1);
        check("step_changed6", changed_a, 1'b1);
      end
      if (i == 7) check("step_pulse_end", {rise_a, 3'b0, changed_a}, 0);
    end

    // Three-cycle glitch on channel 1 is rejected.
    async_in = 4'h3;
    repeat (3) tick();
    async_in = 4'h1;
    repeat (10) begin
      tick();
      check("glitch", {level_a[1], rise_a[1], fall_a[1], changed_a}, 0);
    end

    // Simultaneous rise on ch2 and fall on ch3.
    async_in = 4'h8;
    repeat (12) tick();
    check("multi_pre", level_a, 4'h8);
    async_in = 4'h4;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i < 6) check("multi_hold", level_a, 4'h8);
      if (i == 6) begin
        check("multi_level", level_a, 4'h4);
        check("multi_rise", rise_a, 4'h4);
        check("multi_fall", fall_a, 4'h8);
        check("multi_changed", changed_a, 1'b1);
      end
      if (i == 7) check("multi_changed_end", changed_a, 1'b0);
    end

    // Reset while channel 0 has a partial count of 2.
    async_in = 4'h0;
    repeat (12) tick();
    async_in = 4'h1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("mid_rst", {level_a, rise_a, fall_a, 3'b0, changed_a}, 0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) begin
        check("mid_rel_level", level_a[0], 1'b0);
        check("mid_rel_changed", changed_a, 1'b0);
      end else begin
        check("mid_rel_level6", level_a[0], 1'b1);
        check("mid_rel_rise6", rise_a[0], 1'b1);
      end
    end

    // Unfiltered configuration: step and one-cycle pulse on ch3.
    async_in = 4'h0;
    repeat (12) tick();
    async_in = 4'h8;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) check("b_step_hold", level_b[3], 1'b0);
      else begin
        check("b_step_level", level_b[3], 1'b1);
        check("b_step_rise", rise_b[3], 1'b1);
      end
    end
    repeat (4) tick();
    async_in = 4'h0;
    tick();
    async_in = 4'h8;
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (i == 4) check("b_pulse_fall", {level_b[3], fall_b[3]}, 2'b01);
      if (i == 5) check("b_pulse_rise", {level_b[3], rise_b[3]}, 2'b11);
    end

    // Random toggling with occasional resets.
    repeat (1500) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 5) == 0) async_in[ch] = ~async_in[ch];
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
